calc_cmd_issuer: RTL and testbench

//   Host-side driver for the accumulator calculator breadboard.
//   - Accepts (opcode, operand) commands on a valid/ready stream and buffers them.
//   - Drives the breadboard OP/IN pins one command at a time.
//   - Captures the resulting accumulator value and error flags.
//   - Returns one response per command on a valid/ready stream.
//   - Sits between a host/test sequencer and the breadboard's CLK/IN/OP/OUT/ERR pins.

---
 rtl/calc_pkg.sv | 40 ++++
 rtl/calc_cmd_fifo.sv | 52 +++++
 rtl/calc_cmd_issuer.sv | 144 ++++++++++++++
 tb/tb_calc_cmd_issuer.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the accumulator-calculator command issuer:
// breadboard opcodes, error bit positions, FSM states and the queued command record.
package calc_pkg;

    localparam int OP_W   = 4;
    localparam int ARG_W  = 16;
    localparam int DATA_W = 32;
    localparam int ERR_W  = 2;

    localparam logic [OP_W-1:0] OP_NOP    = 4'd0;
    localparam logic [OP_W-1:0] OP_ADD    = 4'd2;
    localparam logic [OP_W-1:0] OP_SUB    = 4'd3;
    localparam logic [OP_W-1:0] OP_MUL    = 4'd4;
    localparam logic [OP_W-1:0] OP_DIV    = 4'd5;
    localparam logic [OP_W-1:0] OP_MOD    = 4'd6;
    localparam logic [OP_W-1:0] OP_PRESET = 4'd14;
    localparam logic [OP_W-1:0] OP_RESET  = 4'd15;

    localparam int ERR_OVF = 0;
    localparam int ERR_DZE = 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        EXEC,
        CAPT,
        RESP
    } state_t;

    // One queued command as it sits in the FIFO: 20 bits {op, arg}.
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [ARG_W-1:0] arg;
    } cmd_t;

    function automatic logic has_err(input logic [ERR_W-1:0] err);
        return err[ERR_OVF] | err[ERR_DZE];
    endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// Command FIFO for the calculator issuer: DEPTH entries of {op, arg}, power-of-two depth,
// extra pointer bit distinguishes full from empty; flush empties it in one cycle.
module calc_cmd_fifo
    import calc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  cmd_t wr_data,
    output cmd_t rd_data,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cmd_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Flush wins over a same-cycle push so nothing sneaks in behind it.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/calc_cmd_issuer.sv
// Host-side driver for the accumulator calculator breadboard: queues commands, runs them one at a
// time on BB_OP/BB_IN, returns {acc, err} per command. Optional macro: CALC_ERR_FLUSH_EN.
//
// Handshakes: a transfer happens on a rising CLK edge where VALID and READY are both high;
// VALID, once raised, holds its payload stable until that edge (RSP side), and READY may
// depend combinationally on the consumer's own state only.
module calc_cmd_issuer
    import calc_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MUL_WAIT = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [OP_W-1:0]   CMD_OP,
    input  logic [ARG_W-1:0]  CMD_ARG,
    output logic [OP_W-1:0]   BB_OP,
    output logic [ARG_W-1:0]  BB_IN,
    input  logic [DATA_W-1:0] BB_OUT,
    input  logic [ERR_W-1:0]  BB_ERR,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic [ERR_W-1:0]  RSP_ERR,
    output logic              BUSY,
    output state_t            DBG_STATE
);

    localparam int CNT_W = (MUL_WAIT > 1) ? $clog2(MUL_WAIT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MUL_WAIT > 0) ? MUL_WAIT - 1 : 0);

    state_t              state;
    state_t              state_nxt;
    logic [OP_W-1:0]     cur_op;
    logic [ARG_W-1:0]    cur_arg;
    logic [OP_W-1:0]     bb_op_q;
    logic [OP_W-1:0]     bb_op_nxt;
    logic [CNT_W-1:0]    wait_cnt;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [ERR_W-1:0]    rsp_err_q;

    cmd_t                fifo_wr;
    cmd_t                fifo_rd;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_flush;
    logic                fifo_full;
    logic                fifo_empty;
    logic                rsp_accept;

    assign rsp_accept = (state == RESP) && RSP_READY;

`ifdef CALC_ERR_FLUSH_EN
    // An errored response drops everything still queued behind it.
    assign fifo_flush = rsp_accept && has_err(rsp_err_q);
`else
    assign fifo_flush = 1'b0;
`endif

    assign CMD_READY = !fifo_full && !fifo_flush;
    assign fifo_push = CMD_VALID && CMD_READY;
    assign fifo_wr   = '{op: CMD_OP, arg: CMD_ARG};

    calc_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .wr_data (fifo_wr),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next state plus the registered BB_OP value: the opcode is only ever non-NOP for the
    // single cycle spent in EXEC, so the breadboard sees exactly one working edge per command.
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        bb_op_nxt = OP_NOP;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if ((fifo_rd.op == OP_MUL) && (MUL_WAIT > 0)) begin
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = EXEC;
                        bb_op_nxt = fifo_rd.op;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = EXEC;
                    bb_op_nxt = cur_op;
                end
            end
            EXEC: state_nxt = CAPT;
            CAPT: state_nxt = RESP;
            RESP: begin
                if (RSP_READY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            cur_op     <= OP_NOP;
            cur_arg    <= '0;
            bb_op_q    <= OP_NOP;
            wait_cnt   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= '0;
        end else begin
            state   <= state_nxt;
            bb_op_q <= bb_op_nxt;
            if (fifo_pop) begin
                cur_op  <= fifo_rd.op;
                cur_arg <= fifo_rd.arg;
            end
            wait_cnt <= (state == WAIT) ? wait_cnt + CNT_W'(1) : '0;
            // ERR is valid while OP is presented; OUT only after the breadboard latched.
            if (state == EXEC) rsp_err_q  <= BB_ERR;
            if (state == CAPT) rsp_data_q <= BB_OUT;
        end
    end

    assign BB_OP     = bb_op_q;
    assign BB_IN     = cur_arg;
    assign RSP_VALID = (state == RESP);
    assign RSP_DATA  = rsp_data_q;
    assign RSP_ERR   = rsp_err_q;
    assign BUSY      = !fifo_empty || (state != IDLE);
    assign DBG_STATE = state;

endmodule

// File: tb/tb_calc_cmd_issuer.sv
// Directed bench for calc_cmd_issuer driving a behavioural accumulator breadboard.
// Build with +define+CALC_ERR_FLUSH_EN to exercise the error-flush variant.
module tb_calc_cmd_issuer;
    import calc_pkg::*;

    localparam int DEPTH    = 4;
    localparam int MUL_WAIT = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [3:0]  CMD_OP = 4'd0;
    logic [15:0] CMD_ARG = 16'd0;
    logic [3:0]  BB_OP;
    logic [15:0] BB_IN;
    logic [31:0] BB_OUT;
    logic [1:0]  BB_ERR;
    logic        RSP_VALID;
    logic        RSP_READY = 1'b0;
    logic [31:0] RSP_DATA;
    logic [1:0]  RSP_ERR;
    logic        BUSY;
    state_t      dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    calc_cmd_issuer #(
        .DEPTH    (DEPTH),
        .MUL_WAIT (MUL_WAIT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_ARG   (CMD_ARG),
        .BB_OP     (BB_OP),
        .BB_IN     (BB_IN),
        .BB_OUT    (BB_OUT),
        .BB_ERR    (BB_ERR),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_DATA  (RSP_DATA),
        .RSP_ERR   (RSP_ERR),
        .BUSY      (BUSY),
        .DBG_STATE (dbg_state)
    );

    // ---------------- clock / reset block ----------------
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- breadboard model ----------------
    logic [31:0] bb_acc = 32'd0;
    logic [31:0] acc_nxt;
    logic [1:0]  bb_err_m;
    logic [32:0] sum33;
    logic [47:0] prod48;

    always_comb begin
        bb_err_m = 2'b00;
        acc_nxt  = bb_acc;
        sum33    = {1'b0, bb_acc} + {17'd0, BB_IN};
        prod48   = {16'd0, bb_acc} * {32'd0, BB_IN};
        case (BB_OP)
            OP_ADD: begin
                acc_nxt           = sum33[31:0];
                bb_err_m[ERR_OVF] = sum33[32];
            end
            OP_SUB: begin
                acc_nxt           = bb_acc - {16'd0, BB_IN};
                bb_err_m[ERR_OVF] = ({16'd0, BB_IN} > bb_acc);
            end
            OP_MUL: begin
                acc_nxt           = prod48[31:0];
                bb_err_m[ERR_OVF] = |prod48[47:32];
            end
            OP_DIV: begin
                if (BB_IN == 16'd0) begin
                    acc_nxt           = 32'd0;
                    bb_err_m[ERR_DZE] = 1'b1;
                end else begin
                    acc_nxt = bb_acc / {16'd0, BB_IN};
                end
            end
            OP_MOD: begin
                if (BB_IN == 16'd0) begin
                    acc_nxt           = 32'd0;
                    bb_err_m[ERR_DZE] = 1'b1;
                end else begin
                    acc_nxt = bb_acc % {16'd0, BB_IN};
                end
            end
            OP_PRESET: acc_nxt = {16'd0, BB_IN};
            OP_RESET:  acc_nxt = 32'd0;
            default:   acc_nxt = bb_acc;
        endcase
    end

    assign BB_ERR = bb_err_m;
    assign BB_OUT = bb_acc;
    always @(posedge CLK) bb_acc <= acc_nxt;

    // ---------------- pin monitor ----------------
    int          op_edges     = 0;
    int          mul_edges    = 0;
    int          pre_run      = 0;
    int          last_pre_run = 0;
    logic [15:0] run_in       = 16'd0;
    logic [3:0]  last_op      = 4'd0;

    always @(negedge CLK) begin
        if (BB_OP == OP_NOP) begin
            if (BB_IN == run_in) begin
                pre_run = pre_run + 1;
            end else begin
                run_in  = BB_IN;
                pre_run = 1;
            end
        end else begin
            last_pre_run = (BB_IN == run_in) ? pre_run : 0;
            last_op      = BB_OP;
            op_edges     = op_edges + 1;
            if (BB_OP == OP_MUL) mul_edges = mul_edges + 1;
            pre_run = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [3:0] op, input logic [15:0] arg, output int acc_cyc);
        int n;
        n = 0;
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_ARG   = arg;
        while (!CMD_READY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        total_cnt++;
        if (CMD_READY) begin
            @(negedge CLK);
            pass_cnt++;
        end else begin
            $display("FAIL push op=%0d arg=%0h: CMD_READY low for %0d cycles, required high", op, arg, n);
        end
        CMD_VALID = 1'b0;
        acc_cyc   = cyc;
    endtask

    task automatic recv(input logic [31:0] exp_d, input logic [1:0] exp_e, input string name,
                        output int seen_cyc);
        int n;
        n = 0;
        RSP_READY = 1'b1;
        while (!RSP_VALID && n < 200) begin
            @(negedge CLK);
            n++;
        end
        seen_cyc = cyc;
        total_cnt++;
        if (!RSP_VALID) begin
            $display("FAIL %s: no RSP_VALID within 200 cycles, required a response", name);
            seen_cyc = -1000;
        end else if (RSP_DATA !== exp_d || RSP_ERR !== exp_e) begin
            $display("FAIL %s: data=%h err=%b, required data=%h err=%b", name, RSP_DATA, RSP_ERR, exp_d, exp_e);
        end else begin
            pass_cnt++;
        end
        @(negedge CLK);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        total_cnt++;
        if (BB_OP !== 4'd0 || BB_IN !== 16'd0 || RSP_VALID !== 1'b0 || RSP_DATA !== 32'd0 ||
            RSP_ERR !== 2'd0 || BUSY !== 1'b0 || dbg_state !== IDLE) begin
            $display("FAIL reset_values: op=%h in=%h vld=%b data=%h err=%b busy=%b st=%0d, required all zero/IDLE",
                     BB_OP, BB_IN, RSP_VALID, RSP_DATA, RSP_ERR, BUSY, dbg_state);
        end else pass_cnt++;
        RST = 1'b0;
        @(negedge CLK);
        total_cnt++;
        if (CMD_READY !== 1'b1) $display("FAIL reset_ready: CMD_READY=%b, required 1", CMD_READY);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int c0, c1, c2, t0, t1, t2;
        RSP_READY = 1'b1;
        push(OP_RESET, 16'd0, c0);
        push(OP_ADD, 16'd1, c1);
        push(OP_ADD, 16'd5, c2);
        recv(32'd0, 2'b00, "b2b_reset", t0);
        recv(32'd1, 2'b00, "b2b_add1", t1);
        recv(32'd6, 2'b00, "b2b_add5", t2);
        total_cnt++;
        if (t0 - c0 !== 3) $display("FAIL b2b_latency: %0d cycles, required 3", t0 - c0);
        else pass_cnt++;
        total_cnt++;
        if (t1 - t0 !== 4 || t2 - t1 !== 4)
            $display("FAIL b2b_spacing: %0d and %0d cycles, required 4 and 4", t1 - t0, t2 - t1);
        else pass_cnt++;
    endtask

    task automatic test_mul_wait();
        int c, t, mul_before;
        RSP_READY  = 1'b0;
        mul_before = mul_edges;
        push(OP_RESET, 16'd0, c);
        push(OP_ADD, 16'd7, c);
        push(OP_MUL, 16'd3, c);
        recv(32'd0, 2'b00, "mul_reset", t);
        recv(32'd7, 2'b00, "mul_add7", t);
        recv(32'h15, 2'b00, "mul_result", t);
        total_cnt++;
        if (mul_edges - mul_before !== 1 || last_op !== OP_MUL)
            $display("FAIL mul_edges: %0d MUL edges (last op %0d), required 1", mul_edges - mul_before, last_op);
        else pass_cnt++;
        total_cnt++;
        if (last_pre_run !== MUL_WAIT)
            $display("FAIL mul_settle: %0d NOP cycles with IN=3, required %0d", last_pre_run, MUL_WAIT);
        else pass_cnt++;
    endtask

    task automatic test_errors();
        int c, t;
        RSP_READY = 1'b0;
        push(OP_RESET, 16'd0, c);
        push(OP_ADD, 16'd9, c);
        push(OP_DIV, 16'd0, c);
        recv(32'd0, 2'b00, "err_reset", t);
        recv(32'd9, 2'b00, "err_add9", t);
        recv(32'd0, 2'b10, "err_div0", t);
        RSP_READY = 1'b0;
        push(OP_ADD, 16'd9, c);
        push(OP_MOD, 16'd4, c);
        recv(32'd9, 2'b00, "err_add9b", t);
        recv(32'd1, 2'b00, "err_mod4", t);
        RSP_READY = 1'b0;
        push(OP_RESET, 16'd0, c);
        push(OP_SUB, 16'd1, c);
        push(OP_NOP, 16'd0, c);
        recv(32'd0, 2'b00, "ovf_reset", t);
        recv(32'hFFFF_FFFF, 2'b01, "ovf_sub1", t);
        recv(32'hFFFF_FFFF, 2'b00, "nop_read", t);
        push(4'd7, 16'h0055, c);
        recv(32'hFFFF_FFFF, 2'b00, "unused_op7", t);
        total_cnt++;
        if (last_op !== 4'd7) $display("FAIL op7_forward: last BB_OP=%0d, required 7", last_op);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int c, t, snap;
        bit ready_hi;
        RSP_READY = 1'b1;
        push(OP_RESET, 16'd0, c);
        recv(32'd0, 2'b00, "bp_reset", t);
        RSP_READY = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) push(OP_ADD, 16'(i), c);
        total_cnt++;
        if (CMD_READY !== 1'b0) $display("FAIL bp_full: CMD_READY=%b after %0d accepts, required 0", CMD_READY, DEPTH + 1);
        else pass_cnt++;
        CMD_VALID = 1'b1;
        CMD_OP    = OP_ADD;
        CMD_ARG   = 16'd6;
        repeat (4) @(negedge CLK);
        snap     = op_edges;
        ready_hi = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            if (CMD_READY) ready_hi = 1'b1;
        end
        total_cnt++;
        if (ready_hi !== 1'b0) $display("FAIL bp_hold_ready: CMD_READY rose while stalled, required low");
        else pass_cnt++;
        total_cnt++;
        if (op_edges !== snap || BB_OP !== OP_NOP)
            $display("FAIL bp_nop: %0d op edges while stalled (BB_OP=%0d), required 0 and NOP", op_edges - snap, BB_OP);
        else pass_cnt++;
        total_cnt++;
        if (RSP_VALID !== 1'b1 || RSP_DATA !== 32'd1)
            $display("FAIL bp_stable: vld=%b data=%h, required 1 and 1", RSP_VALID, RSP_DATA);
        else pass_cnt++;
        CMD_VALID = 1'b0;
        recv(32'd1, 2'b00, "bp_r1", t);
        push(OP_ADD, 16'd6, c);
        recv(32'd3, 2'b00, "bp_r2", t);
        recv(32'd6, 2'b00, "bp_r3", t);
        recv(32'd10, 2'b00, "bp_r4", t);
        recv(32'd15, 2'b00, "bp_r5", t);
        recv(32'd21, 2'b00, "bp_r6", t);
        total_cnt++;
        if (BUSY !== 1'b0) $display("FAIL bp_idle: BUSY=%b after drain, required 0", BUSY);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int c, t, n;
        bit rsp_seen;
        RSP_READY = 1'b1;
        push(OP_RESET, 16'd0, c);
        recv(32'd0, 2'b00, "mr_reset", t);
        push(OP_ADD, 16'd5, c);
        n = 0;
        while (BB_OP !== OP_ADD && n < 50) begin
            @(negedge CLK);
            n++;
        end
        total_cnt++;
        if (BB_OP !== OP_ADD) $display("FAIL mr_exec: BB_OP=%0d, required ADD", BB_OP);
        else pass_cnt++;
        RST = 1'b1;
        #1;
        total_cnt++;
        if (BB_OP !== 4'd0 || RSP_VALID !== 1'b0 || BUSY !== 1'b0)
            $display("FAIL mr_during: op=%0d vld=%b busy=%b, required 0/0/0", BB_OP, RSP_VALID, BUSY);
        else pass_cnt++;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        rsp_seen = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            if (RSP_VALID || BB_OP != OP_NOP) rsp_seen = 1'b1;
        end
        total_cnt++;
        if (rsp_seen !== 1'b0 || BUSY !== 1'b0 || CMD_READY !== 1'b1 || dbg_state !== IDLE)
            $display("FAIL mr_after: activity=%b busy=%b rdy=%b st=%0d, required 0/0/1/IDLE",
                     rsp_seen, BUSY, CMD_READY, dbg_state);
        else pass_cnt++;
        total_cnt++;
        if (bb_acc !== 32'd0) $display("FAIL mr_acc: accumulator=%h, required 0 (ADD abandoned)", bb_acc);
        else pass_cnt++;
        push(OP_ADD, 16'd2, c);
        recv(32'd2, 2'b00, "mr_resume", t);
    endtask

    task automatic test_err_flush();
        int c, t, n, extra;
        RSP_READY = 1'b1;
        push(OP_RESET, 16'd0, c);
        recv(32'd0, 2'b00, "fl_reset", t);
        RSP_READY = 1'b0;
        push(OP_DIV, 16'd0, c);
        push(OP_ADD, 16'd1, c);
        push(OP_ADD, 16'd2, c);
        n = 0;
        while (!RSP_VALID && n < 50) begin
            @(negedge CLK);
            n++;
        end
        total_cnt++;
        if (RSP_VALID !== 1'b1 || RSP_DATA !== 32'd0 || RSP_ERR !== 2'b10)
            $display("FAIL fl_div0: vld=%b data=%h err=%b, required 1/0/10", RSP_VALID, RSP_DATA, RSP_ERR);
        else pass_cnt++;
        RSP_READY = 1'b1;
        #1;
        total_cnt++;
`ifdef CALC_ERR_FLUSH_EN
        if (CMD_READY !== 1'b0) $display("FAIL fl_ready: CMD_READY=%b in flush cycle, required 0", CMD_READY);
        else pass_cnt++;
`else
        if (CMD_READY !== 1'b1) $display("FAIL fl_ready: CMD_READY=%b, required 1", CMD_READY);
        else pass_cnt++;
`endif
        @(negedge CLK);
`ifdef CALC_ERR_FLUSH_EN
        extra = 0;
        repeat (20) begin
            @(negedge CLK);
            if (RSP_VALID) extra++;
        end
        total_cnt++;
        if (extra !== 0 || BUSY !== 1'b0)
            $display("FAIL fl_flushed: %0d extra responses busy=%b, required 0 and 0", extra, BUSY);
        else pass_cnt++;
        push(OP_ADD, 16'd4, c);
        recv(32'd4, 2'b00, "fl_after", t);
`else
        extra = 0;
        recv(32'd1, 2'b00, "fl_add1", t);
        recv(32'd3, 2'b00, "fl_add2", t);
        total_cnt++;
        if (BUSY !== 1'b0 || extra !== 0) $display("FAIL fl_idle: BUSY=%b, required 0", BUSY);
        else pass_cnt++;
        push(OP_ADD, 16'd4, c);
        recv(32'd7, 2'b00, "fl_after", t);
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        @(negedge CLK);
        test_reset();
        test_back_to_back();
        test_mul_wait();
        test_errors();
        test_backpressure();
        test_mid_reset();
        test_err_flush();
        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
